// File: rtl/nrzi_pkg.sv
// rtl/nrzi_pkg.sv - shared constants and types for the NRZI phase-lock decoder
package nrzi_pkg;

   localparam int OVERSAMPLE     = 4;
   localparam int SYNC_ZEROS     = 10;
   localparam int LOCK_LOSS_BITS = 16;

   typedef logic [1:0] ph_t;
   typedef logic [3:0] zrun_t;

   typedef enum logic {
      LOCK_IDLE = 1'b0,
      LOCK_HELD = 1'b1
   } lock_state_e;

   // An edge cycle counts as phase 0, so the counter resumes at 1; the tick fires leaving mid-bit-1.
   localparam ph_t   PH_EDGE   = ph_t'(1);
   localparam ph_t   PH_TICK   = ph_t'(OVERSAMPLE / 2 - 1);
   localparam zrun_t ZRUN_SYNC = zrun_t'(SYNC_ZEROS);
   localparam zrun_t ZRUN_LOSS = zrun_t'(LOCK_LOSS_BITS - 1);

   function automatic zrun_t zrun_next(input zrun_t zrun, input logic bit_val);
      zrun_t r;
      r = zrun;
      if (bit_val)
         r = '0;
      else if (zrun != '1)
         r = zrun + zrun_t'(1);
      return r;
   endfunction

endpackage

// File: rtl/nrzi_sync_2ff.sv
// rtl/nrzi_sync_2ff.sv - two-flop synchronizer for the asynchronous NRZI line
module nrzi_sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/nrzi_phase_lock_decoder.sv
// rtl/nrzi_phase_lock_decoder.sv - 4x oversampled NRZI decoder with phase realignment, lock and sync detect
module nrzi_phase_lock_decoder
   import nrzi_pkg::*;
(
   input  logic clk_x4_i,
   input  logic rst_ni,
   input  logic nrzi_i,
   output logic clk_o,
   output logic clk_main_tick_no,
   output logic data_o,
   output logic valid_o,
   output logic sync_o
);

   logic        line_sync;
   logic        line_hist;
   logic        edge_det;
   logic        tick;
   ph_t         ph_q;
   logic        edge_seen_q;
   zrun_t       zrun_q;
   logic        tick_n_q;
   logic        data_q;
   logic        sync_q;
   lock_state_e lock_q;
   lock_state_e lock_d;

   nrzi_sync_2ff u_sync (
      .clk   (clk_x4_i),
      .rst_n (rst_ni),
      .d     (nrzi_i),
      .q     (line_sync)
   );

   assign edge_det = line_sync ^ line_hist;
   // An edge landing on the tick cycle wins: the counter realigns and the bit is reported one cycle later.
   assign tick     = (ph_q == PH_TICK) && !edge_det;

   always_ff @(posedge clk_x4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         line_hist   <= 1'b0;
         ph_q        <= '0;
         edge_seen_q <= 1'b0;
         zrun_q      <= '0;
         tick_n_q    <= 1'b1;
         data_q      <= 1'b0;
         sync_q      <= 1'b0;
      end else begin
         line_hist <= line_sync;
         ph_q      <= edge_det ? PH_EDGE : ph_q + ph_t'(1);
         tick_n_q  <= !tick;
         sync_q    <= tick && edge_seen_q && (zrun_q >= ZRUN_SYNC);

         if (edge_det)
            edge_seen_q <= 1'b1;
         else if (tick)
            edge_seen_q <= 1'b0;

         if (tick) begin
            data_q <= edge_seen_q;
            zrun_q <= zrun_next(zrun_q, edge_seen_q);
         end
      end
   end

   always_ff @(posedge clk_x4_i or negedge rst_ni) begin
      if (!rst_ni)
         lock_q <= LOCK_IDLE;
      else
         lock_q <= lock_d;
   end

   always_comb begin
      lock_d = lock_q;
      if (tick) begin
         case (lock_q)
            LOCK_IDLE: if (edge_seen_q) lock_d = LOCK_HELD;
            LOCK_HELD: if (!edge_seen_q && zrun_q == ZRUN_LOSS) lock_d = LOCK_IDLE;
            default:   lock_d = LOCK_IDLE;
         endcase
      end
   end

   assign clk_o            = ph_q[1];
   assign clk_main_tick_no = tick_n_q;
   assign data_o           = data_q;
   assign sync_o           = sync_q;
   assign valid_o          = (lock_q == LOCK_HELD);

endmodule

// File: tb/tb_nrzi_phase_lock_decoder.sv
// tb/tb_nrzi_phase_lock_decoder.sv - scoreboard bench for the NRZI phase-lock decoder
`timescale 1ns/10ps
module tb_nrzi_phase_lock_decoder;

   typedef struct {
      bit data;
      bit sync;
      bit valid;
      int gap;
      bit chk;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic line  = 1'b0;
   logic clk_o, tick_n, data, valid, sync;

   int    tests = 0;
   int    fails = 0;
   int    cyc = 0;
   int    last_tick = 0;
   string scn = "reset";
   exp_t  sb[$];
   exp_t  mon_e;
   bit    tx_bits[$];
   int    tx_gap[$];
   int    m_zrun = 0;
   bit    m_valid = 1'b0;

   nrzi_phase_lock_decoder dut (
      .clk_x4_i         (clk),
      .rst_ni           (rst_n),
      .nrzi_i           (line),
      .clk_o            (clk_o),
      .clk_main_tick_no (tick_n),
      .data_o           (data),
      .valid_o          (valid),
      .sync_o           (sync)
   );

   always #2 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference behaviour: zero-run, sync and lock evolve in bit order as each bit is transmitted.
   task automatic push_bit(input bit b, input int gap, input bit chk);
      exp_t e;
      e.data = b;
      e.sync = b && (m_zrun >= 10);
      if (b) begin
         m_zrun  = 0;
         m_valid = 1'b1;
      end else begin
         if (m_zrun == 15) m_valid = 1'b0;
         if (m_zrun < 15) m_zrun++;
      end
      e.valid = m_valid;
      e.gap   = gap;
      e.chk   = chk;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (!tick_n) begin
            check({scn, "_clk_o_at_tick"}, int'(clk_o), 1);
            if (sb.size() > 0) begin
               mon_e = sb.pop_front();
               if (mon_e.chk) begin
                  check({scn, "_data"},  int'(data),  int'(mon_e.data));
                  check({scn, "_sync"},  int'(sync),  int'(mon_e.sync));
                  check({scn, "_valid"}, int'(valid), int'(mon_e.valid));
               end
               if (mon_e.gap != 0)
                  check({scn, "_tick_gap"}, cyc - last_tick, mon_e.gap);
            end
            last_tick = cyc;
         end else begin
            check({scn, "_sync_idle"}, int'(sync), 0);
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      line  = 1'b0;
      repeat (3) @(negedge clk);
      sb.delete();
      m_zrun  = 0;
      m_valid = 1'b0;
      rst_n   = 1'b1;
   endtask

   // Arms on a free-running tick so the first edge lands at phase 0; bit k nominally starts base+16k.
   task automatic run_stream(input bit jit, input int late_idx, input int skip);
      realtime base, t;
      bit armed = 1'b0;
      for (int i = 0; i < 16 && !armed; i++) begin
         @(negedge clk);
         if (!tick_n) armed = 1'b1;
      end
      check({scn, "_arm"}, int'(armed), 1);
      if (!armed) return;
      #1;
      base = $realtime;
      for (int k = 0; k < tx_bits.size(); k++) begin
         t = base + 16.0 * k;
         if (jit && k > 0)
            t = t + 1.0 + (real'($urandom_range(0, 37)) - 18.5) / 10.0;
         if (k == late_idx) t = t + 4.0;
         if (t > $realtime) #(t - $realtime);
         if (tx_bits[k]) line = ~line;
         push_bit(tx_bits[k], tx_gap[k], k >= skip);
      end
      for (int i = 0; i < 80 && sb.size() > 0; i++) @(negedge clk);
      check({scn, "_drain"}, sb.size(), 0);
      sb.delete();
   endtask

   task automatic load(input int n, input int gap);
      tx_bits.delete();
      tx_gap.delete();
      for (int i = 0; i < n; i++) begin
         tx_bits.push_back(1'b0);
         tx_gap.push_back(gap);
      end
   endtask

   initial begin
      // Reset held while the line toggles.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         line = ~line;
         check("reset_tick_n", int'(tick_n), 1);
         check("reset_valid",  int'(valid),  0);
      end
      @(negedge clk);
      check("reset_clk_o", int'(clk_o), 0);
      check("reset_data",  int'(data),  0);
      check("reset_sync",  int'(sync),  0);

      scn = "pattern";
      do_reset();
      load(5, 4);
      tx_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      run_stream(1'b0, -1, 0);

      scn = "async_reset";
      @(negedge clk);
      check("async_pre_valid", int'(valid), 1);
      #0.5 rst_n = 1'b0;
      #0.5;
      check("async_valid",  int'(valid),  0);
      check("async_tick_n", int'(tick_n), 1);
      check("async_clk_o",  int'(clk_o),  0);
      check("async_data",   int'(data),   0);

      scn = "sync";
      do_reset();
      load(12, 0);
      tx_bits[0]  = 1'b1;
      tx_bits[11] = 1'b1;
      run_stream(1'b0, -1, 0);

      scn = "lock_loss";
      do_reset();
      load(21, 4);
      tx_bits[0] = 1'b1;
      run_stream(1'b0, -1, 0);
      repeat (8) @(negedge clk);
      check("lock_loss_stays_low", int'(valid), 0);

      scn = "edge_on_tick";
      do_reset();
      load(4, 4);
      tx_bits = '{1'b1, 1'b1, 1'b0, 1'b1};
      tx_gap  = '{4, 5, 4, 3};
      run_stream(1'b0, 1, 0);

      scn = "jitter";
      do_reset();
      load(512, 0);
      tx_bits[0] = 1'b1;
      for (int i = 1; i < 512; i++) tx_bits[i] = 1'($urandom_range(0, 1));
      run_stream(1'b1, -1, 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d tests expected completion", tests);
      $fatal(1);
   end

endmodule
